// File: rtl/riscv32ima_mem_arbiter.sv
// Shares one single-port memory between the fetch and data ports of the core.
// Data has priority, fetch starvation is bounded, and grants are held across memory stalls.
module riscv32ima_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned MAX_DBURST = 4
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  f_ncs,
  input  logic                  f_nwe,
  input  logic [ADDR_WIDTH-1:0] f_addr,
  input  logic [DATA_WIDTH-1:0] f_wdata,
  input  logic [DATA_WIDTH-1:0] f_wmask,
  output logic [DATA_WIDTH-1:0] f_rdata,
  output logic                  f_stall,
  input  logic                  d_ncs,
  input  logic                  d_nwe,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic [DATA_WIDTH-1:0] d_wmask,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_stall,
  output logic                  m_ncs,
  output logic                  m_nwe,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic [DATA_WIDTH-1:0] m_wmask,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic                  m_stall
);

  localparam int unsigned DCNT_W = $clog2(MAX_DBURST + 1);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_F    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  owner_t              r_lock;
  owner_t              r_rsel;
  owner_t              w_grant;
  owner_t              w_lock_nxt;
  owner_t              w_rsel_nxt;
  logic [DCNT_W-1:0]   r_dcnt;
  logic [DCNT_W-1:0]   w_dcnt_nxt;
  logic                w_f_req;
  logic                w_d_req;
  logic                w_accept;
  logic                w_dcnt_max;

  assign w_f_req    = ~f_ncs;
  assign w_d_req    = ~d_ncs;
  assign w_dcnt_max = (r_dcnt == DCNT_W'(MAX_DBURST));

  // State registers: lock owner, read-data steering, data burst counter.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_lock <= OWN_NONE;
      r_rsel <= OWN_NONE;
      r_dcnt <= '0;
    end else begin
      r_lock <= w_lock_nxt;
      r_rsel <= w_rsel_nxt;
      r_dcnt <= w_dcnt_nxt;
    end
  end

  // Grant selection and next-state; grant is suppressed while reset is held.
  always_comb begin
    w_grant    = OWN_NONE;
    w_lock_nxt = OWN_NONE;
    w_rsel_nxt = OWN_NONE;
    w_dcnt_nxt = r_dcnt;

    if (!nrst) begin
      w_grant = OWN_NONE;
    end else if ((r_lock == OWN_F) && w_f_req) begin
      w_grant = OWN_F;
    end else if ((r_lock == OWN_D) && w_d_req) begin
      w_grant = OWN_D;
    end else if (w_f_req && w_d_req) begin
      w_grant = w_dcnt_max ? OWN_F : OWN_D;
    end else if (w_f_req) begin
      w_grant = OWN_F;
    end else if (w_d_req) begin
      w_grant = OWN_D;
    end

    w_accept = (w_grant != OWN_NONE) && !m_stall;

    if (m_stall && (w_grant != OWN_NONE)) begin
      w_lock_nxt = w_grant;
    end

    if (w_accept && m_nwe) begin
      w_rsel_nxt = w_grant;
    end

    // Count consecutive data wins only while fetch is actually waiting.
    if (!w_f_req || (w_accept && (w_grant == OWN_F))) begin
      w_dcnt_nxt = '0;
    end else if (w_accept && (w_grant == OWN_D) && !w_dcnt_max) begin
      w_dcnt_nxt = r_dcnt + DCNT_W'(1);
    end
  end

  // Request mux towards memory.
  always_comb begin
    m_ncs   = 1'b1;
    m_nwe   = 1'b1;
    m_addr  = '0;
    m_wdata = '0;
    m_wmask = '0;
    case (w_grant)
      OWN_F: begin
        m_ncs   = 1'b0;
        m_nwe   = f_nwe;
        m_addr  = f_addr;
        m_wdata = f_wdata;
        m_wmask = f_wmask;
      end
      OWN_D: begin
        m_ncs   = 1'b0;
        m_nwe   = d_nwe;
        m_addr  = d_addr;
        m_wdata = d_wdata;
        m_wmask = d_wmask;
      end
      default: ;
    endcase
  end

  assign f_stall = w_f_req & ~((w_grant == OWN_F) & ~m_stall);
  assign d_stall = w_d_req & ~((w_grant == OWN_D) & ~m_stall);
  assign f_rdata = (r_rsel == OWN_F) ? m_rdata : '0;
  assign d_rdata = (r_rsel == OWN_D) ? m_rdata : '0;

endmodule

// File: tb/tb_riscv32ima_mem_arbiter.sv
// Directed bench for riscv32ima_mem_arbiter: one table row per clock cycle,
// followed by a hand-written burst-counter sequence.
module tb_riscv32ima_mem_arbiter;

  localparam logic [63:0] F_MASK = 64'h0000_0000_0000_000F;

  logic        clk;
  logic        nrst;
  logic        f_ncs, f_nwe, d_ncs, d_nwe;
  logic [31:0] f_addr, d_addr, m_addr;
  logic [63:0] f_wdata, f_wmask, d_wdata, d_wmask;
  logic [63:0] f_rdata, d_rdata, m_wdata, m_wmask, m_rdata;
  logic        f_stall, d_stall, m_ncs, m_nwe, m_stall;

  int checks   = 0;
  int failures = 0;

  riscv32ima_mem_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(64), .MAX_DBURST(4)
  ) dut (
    .clk(clk), .nrst(nrst),
    .f_ncs(f_ncs), .f_nwe(f_nwe), .f_addr(f_addr), .f_wdata(f_wdata),
    .f_wmask(f_wmask), .f_rdata(f_rdata), .f_stall(f_stall),
    .d_ncs(d_ncs), .d_nwe(d_nwe), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wmask(d_wmask), .d_rdata(d_rdata), .d_stall(d_stall),
    .m_ncs(m_ncs), .m_nwe(m_nwe), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wmask(m_wmask), .m_rdata(m_rdata), .m_stall(m_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // own: 0 = no grant, 1 = fetch, 2 = data
  typedef struct {
    logic        rst_n;
    logic        f_ncs;
    logic        f_nwe;
    logic [31:0] f_addr;
    logic        d_ncs;
    logic        d_nwe;
    logic [31:0] d_addr;
    logic [63:0] d_wmask;
    logic        m_stall;
    logic [63:0] m_rdata;
    logic [1:0]  own;
    logic        f_stall;
    logic        d_stall;
    logic [63:0] f_rdata;
    logic [63:0] d_rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst_n, input logic fncs, input logic fnwe,
                     input logic [31:0] faddr, input logic dncs, input logic dnwe,
                     input logic [31:0] daddr, input logic [63:0] dwmask,
                     input logic mst, input logic [63:0] mrd, input logic [1:0] own,
                     input logic fst, input logic dst, input logic [63:0] frd,
                     input logic [63:0] drd);
    vec_t v;
    v.rst_n = rst_n; v.f_ncs = fncs; v.f_nwe = fnwe; v.f_addr = faddr;
    v.d_ncs = dncs; v.d_nwe = dnwe; v.d_addr = daddr; v.d_wmask = dwmask;
    v.m_stall = mst; v.m_rdata = mrd; v.own = own; v.f_stall = fst;
    v.d_stall = dst; v.f_rdata = frd; v.d_rdata = drd;
    vecs.push_back(v);
  endtask

  task automatic chk(input int idx, input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL step%0d %s: got %h expected %h", idx, name, act, exp);
    end
  endtask

  task automatic drive(input logic rst_n, input logic fncs, input logic fnwe,
                       input logic [31:0] faddr, input logic dncs, input logic dnwe,
                       input logic [31:0] daddr, input logic [63:0] dwmask,
                       input logic mst, input logic [63:0] mrd);
    nrst = rst_n; f_ncs = fncs; f_nwe = fnwe; f_addr = faddr;
    f_wdata = {32'hF00D_0000, faddr}; f_wmask = F_MASK;
    d_ncs = dncs; d_nwe = dnwe; d_addr = daddr;
    d_wdata = {32'hDA7A_0000, daddr}; d_wmask = dwmask;
    m_stall = mst; m_rdata = mrd;
  endtask

  initial begin
    logic        e_ncs, e_nwe;
    logic [31:0] e_addr;
    logic [63:0] e_wdata, e_wmask;

    drive(1'b0, 1'b1, 1'b1, 32'h0, 1'b1, 1'b1, 32'h0, 64'h0, 1'b0, 64'h0);

    // rst fncs fnwe faddr dncs dnwe daddr dwmask mst mrdata | own fst dst frd drd
    add(0, 0, 1, 32'h100, 0, 1, 32'h200, 64'hFF, 0, 64'h55,   0, 1, 1, 64'h0, 64'h0);
    add(1, 0, 1, 32'h100, 0, 1, 32'h200, 64'hFF, 0, 64'h55,   2, 1, 0, 64'h0, 64'h0);
    add(1, 0, 1, 32'h100, 0, 1, 32'h204, 64'hFF, 0, 64'h1003, 2, 1, 0, 64'h0, 64'h1003);
    add(1, 0, 1, 32'h100, 0, 1, 32'h208, 64'hFF, 0, 64'h1004, 2, 1, 0, 64'h0, 64'h1004);
    add(1, 0, 1, 32'h100, 0, 1, 32'h20C, 64'hFF, 0, 64'h1005, 2, 1, 0, 64'h0, 64'h1005);
    add(1, 0, 1, 32'h100, 0, 1, 32'h210, 64'hFF, 0, 64'h1006, 1, 0, 1, 64'h0, 64'h1006);
    add(1, 0, 1, 32'h104, 0, 1, 32'h210, 64'hFF, 0, 64'h1007, 2, 1, 0, 64'h1007, 64'h0);
    add(1, 0, 1, 32'h104, 0, 1, 32'h214, 64'hFF, 0, 64'h1008, 2, 1, 0, 64'h0, 64'h1008);
    add(1, 0, 1, 32'h104, 0, 1, 32'h218, 64'hFF, 0, 64'h1009, 2, 1, 0, 64'h0, 64'h1009);
    add(1, 0, 1, 32'h104, 0, 1, 32'h21C, 64'hFF, 0, 64'h100A, 2, 1, 0, 64'h0, 64'h100A);
    add(1, 0, 1, 32'h104, 0, 1, 32'h220, 64'hFF, 0, 64'h100B, 1, 0, 1, 64'h0, 64'h100B);
    add(1, 1, 1, 32'h0,   1, 1, 32'h0,   64'h0,  0, 64'hAC,   0, 0, 0, 64'hAC, 64'h0);
    // fetch only
    add(1, 0, 1, 32'h100, 1, 1, 32'h0,   64'h0,  0, 64'h0,    1, 0, 0, 64'h0, 64'h0);
    add(1, 1, 1, 32'h0,   1, 1, 32'h0,   64'h0,  0, 64'hAA,   0, 0, 0, 64'hAA, 64'h0);
    // stall lock: data arrives while fetch is stalled
    add(1, 0, 1, 32'h300, 1, 1, 32'h0,   64'h0,  1, 64'h0,    1, 1, 0, 64'h0, 64'h0);
    add(1, 0, 1, 32'h300, 0, 1, 32'h400, 64'hFF, 1, 64'h0,    1, 1, 1, 64'h0, 64'h0);
    add(1, 0, 1, 32'h300, 0, 1, 32'h400, 64'hFF, 1, 64'h0,    1, 1, 1, 64'h0, 64'h0);
    add(1, 0, 1, 32'h300, 0, 1, 32'h400, 64'hFF, 0, 64'h0,    1, 0, 1, 64'h0, 64'h0);
    // data read then fetch read, back to back
    add(1, 1, 1, 32'h0,   0, 1, 32'h400, 64'hFF, 0, 64'h77,   2, 0, 0, 64'h77, 64'h0);
    add(1, 0, 1, 32'h500, 1, 1, 32'h0,   64'h0,  0, 64'h11,   1, 0, 0, 64'h0, 64'h11);
    add(1, 1, 1, 32'h0,   1, 1, 32'h0,   64'h0,  0, 64'h22,   0, 0, 0, 64'h22, 64'h0);
    // data write produces no read steering
    add(1, 1, 1, 32'h0,   0, 0, 32'h600, 64'hFF, 0, 64'h33,   2, 0, 0, 64'h0, 64'h0);
    add(1, 1, 1, 32'h0,   1, 1, 32'h0,   64'h0,  0, 64'h44,   0, 0, 0, 64'h0, 64'h0);
    // locked owner withdraws under stall
    add(1, 1, 1, 32'h0,   0, 1, 32'h700, 64'hFF, 1, 64'h0,    2, 0, 1, 64'h0, 64'h0);
    add(1, 0, 1, 32'h800, 1, 1, 32'h0,   64'h0,  1, 64'h0,    1, 1, 0, 64'h0, 64'h0);
    add(1, 0, 1, 32'h800, 1, 1, 32'h0,   64'h0,  0, 64'h0,    1, 0, 0, 64'h0, 64'h0);
    add(1, 1, 1, 32'h0,   1, 1, 32'h0,   64'h0,  0, 64'h99,   0, 0, 0, 64'h99, 64'h0);
    // reset while a read is in flight
    add(1, 0, 1, 32'h900, 1, 1, 32'h0,   64'h0,  0, 64'h0,    1, 0, 0, 64'h0, 64'h0);
    add(0, 0, 1, 32'h900, 1, 1, 32'h0,   64'h0,  0, 64'hBB,   0, 1, 0, 64'h0, 64'h0);
    add(1, 1, 1, 32'h0,   1, 1, 32'h0,   64'h0,  0, 64'hCC,   0, 0, 0, 64'h0, 64'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i].rst_n, vecs[i].f_ncs, vecs[i].f_nwe, vecs[i].f_addr,
            vecs[i].d_ncs, vecs[i].d_nwe, vecs[i].d_addr, vecs[i].d_wmask,
            vecs[i].m_stall, vecs[i].m_rdata);
      #3;
      e_ncs = 1'b1; e_nwe = 1'b1; e_addr = '0; e_wdata = '0; e_wmask = '0;
      if (vecs[i].own == 2'd1) begin
        e_ncs = 1'b0; e_nwe = vecs[i].f_nwe; e_addr = vecs[i].f_addr;
        e_wdata = {32'hF00D_0000, vecs[i].f_addr}; e_wmask = F_MASK;
      end else if (vecs[i].own == 2'd2) begin
        e_ncs = 1'b0; e_nwe = vecs[i].d_nwe; e_addr = vecs[i].d_addr;
        e_wdata = {32'hDA7A_0000, vecs[i].d_addr}; e_wmask = vecs[i].d_wmask;
      end
      chk(i, "m_ncs",   64'(m_ncs),   64'(e_ncs));
      chk(i, "m_nwe",   64'(m_nwe),   64'(e_nwe));
      chk(i, "m_addr",  64'(m_addr),  64'(e_addr));
      chk(i, "m_wdata", m_wdata,      e_wdata);
      chk(i, "m_wmask", m_wmask,      e_wmask);
      chk(i, "f_stall", 64'(f_stall), 64'(vecs[i].f_stall));
      chk(i, "d_stall", 64'(d_stall), 64'(vecs[i].d_stall));
      chk(i, "f_rdata", f_rdata,      vecs[i].f_rdata);
      chk(i, "d_rdata", d_rdata,      vecs[i].d_rdata);
    end

    // Four data wins with fetch waiting, then fetch drops for one cycle:
    // the burst count clears, so data wins again afterwards.
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      drive(1'b1, 1'b0, 1'b1, 32'hA00, 1'b0, 1'b1, 32'hB00 + 32'(k), 64'hFF, 1'b0, 64'h0);
      #3;
      chk(100 + k, "burst_addr",  64'(m_addr),  64'h0000_0B00 + 64'(k));
      chk(100 + k, "burst_fstall", 64'(f_stall), 64'h1);
    end
    @(posedge clk);
    #1;
    drive(1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 1'b1, 32'hB10, 64'hFF, 1'b0, 64'h0);
    #3;
    chk(104, "fdrop_addr", 64'(m_addr), 64'h0000_0B10);
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 1'b1, 32'hA00, 1'b0, 1'b1, 32'hB14, 64'hFF, 1'b0, 64'h0);
    #3;
    chk(105, "after_drop_addr",  64'(m_addr),  64'h0000_0B14);
    chk(105, "after_drop_fstall", 64'(f_stall), 64'h1);
    chk(105, "after_drop_dstall", 64'(d_stall), 64'h0);
    @(posedge clk);
    #1;
    drive(1'b1, 1'b1, 1'b1, 32'h0, 1'b1, 1'b1, 32'h0, 64'h0, 1'b0, 64'h0);
    #3;
    chk(106, "idle_ncs", 64'(m_ncs), 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv32ima_mem_arbiter.md
# riscv32ima_mem_arbiter

Two-requester arbiter sharing one single-port memory between the instruction-fetch port and the load/store (data) port of the riscv32ima core. Both requesters and the memory use the core's active-low chip-select bus (ncs/nwe/addr/wdata/wmask/rdata/stall). The arbiter grants data accesses by priority and bounds fetch starvation with a burst counter. It holds a grant stable while memory stalls, and steers read data to the requester that issued the read.

## Interface
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 64, data/mask width of all ports
- MAX_DBURST, 4, max consecutive data grants while fetch waits (>=1)
- clk  in  1  clock, rising edge
- nrst  in  1  asynchronous active-low reset
- f_ncs, f_nwe  in  1 each  fetch request (0 = request), write enable (0 = write)
- f_addr  in  ADDR_WIDTH  fetch address
- f_wdata, f_wmask  in  DATA_WIDTH each  fetch write data/mask
- f_rdata  out  DATA_WIDTH  fetch read data
- f_stall  out  1  fetch must hold request
- d_ncs, d_nwe, d_addr, d_wdata, d_wmask  in  as f_*  data-port request
- d_rdata  out  DATA_WIDTH  data read data
- d_stall  out  1  data port must hold request
- m_ncs, m_nwe  out  1 each  memory request/write enable
- m_addr  out  ADDR_WIDTH; m_wdata, m_wmask  out  DATA_WIDTH  memory request fields
- m_rdata  in  DATA_WIDTH  memory read data
- m_stall  in  1  memory not accepting

## Operation
- Bus rule: transfer accepted at rising edge with ncs=0 and stall=0; read data valid on rdata the cycle after acceptance; requester holds all fields while stall=1.
- Requests: f_req = ~f_ncs, d_req = ~d_ncs.
- Lock register lock ∈ {NONE, F, D}. Grant (combinational): if lock≠NONE and that requester still requests, grant = lock; else if only one requests, grant it; else if both, grant D unless dcnt == MAX_DBURST, then F; else none.
- Lock update per edge: lock <= grant if m_stall=1 and grant≠none; else NONE. Prevents switching owner under a memory stall.
- Mux: m_ncs = ~(grant≠none); m_nwe/m_addr/m_wdata/m_wmask from granted port; when no grant, m_nwe=1 and the other fields are 0.
- Stalls: f_stall = f_req & ~(grant==F & ~m_stall); d_stall likewise for D. Non-requesting port stall = 0.
- dcnt (width clog2(MAX_DBURST+1)): on a data acceptance with f_req=1, dcnt <= dcnt+1, saturating at MAX_DBURST; on a fetch acceptance, or in any cycle with f_req=0, dcnt <= 0.
- Read steering: rsel register ∈ {NONE, F, D}. rsel <= owner on acceptance of a read (m_nwe=1); otherwise rsel <= NONE. f_rdata = m_rdata if rsel==F, else 0. d_rdata = m_rdata if rsel==D, else 0.
- Writes produce no rsel.

## Timing
- Reset (nrst=0, async): lock=NONE, dcnt=0, rsel=NONE. Consequently m_ncs=1, m_nwe=1, m_addr/m_wdata/m_wmask=0, f_rdata=d_rdata=0, and the stalls follow the request inputs combinationally.
- Zero-cycle grant: request and m_ncs in the same cycle. Read data reaches the requester 1 cycle after acceptance.
- Back-to-back accepts are allowed every cycle, including alternating owners. rsel tracks each accept independently.
- Simultaneous requests, dcnt<MAX_DBURST: D accepted, f_stall=1.
- After MAX_DBURST consecutive D accepts with F waiting, the next grant is F.
- m_stall=1 with both requesting: the owner is held until accepted even if the other request arrives. dcnt does not change during stall cycles.
- If the locked owner withdraws its request (protocol violation), the lock is released in the same cycle.
- Reset asserted mid-transfer: state clears immediately; a pending read's data is dropped (rsel=NONE).

## Test plan
- Reset: nrst=0 with both requesting → m_ncs=1 while in reset, rdata=0; after release, D granted, d_stall=0, f_stall=1.
- Fetch only: f_ncs=0, addr=0x100, m_stall=0, m_rdata=0xAA next cycle → m_addr=0x100, f_stall=0; f_rdata=0xAA, d_rdata=0 in the following cycle.
- Starvation bound: both request continuously, MAX_DBURST=4 → grant sequence D,D,D,D,F,D,D,D,D,F.
- Stall lock: F granted, m_stall=1 for 3 cycles, d request arrives in cycle 2 → m_addr stays at the fetch address, d_stall=1 throughout; F accepted when m_stall drops, D granted next.
- Alternating reads: D read accept then F read accept on consecutive cycles, m_rdata=0x11 then 0x22 → d_rdata=0x11 then f_rdata=0x22, the other port reads 0 in each cycle.
- Write: d_nwe=0, wmask=0xFF → passed to m_* unchanged, rsel stays NONE, both rdata=0 the next cycle.
